status_packet_encoder: RTL and testbench
========================================

Name: status_packet_encoder

Overview:
- Periodic telemetry serializer for the UART transmit path.
- Every PERIOD_S one-second ticks, or on demand, it snapshots N_CH status flags and emits a packet byte by byte over a valid/ready handshake to the UART transmitter.
- Packet format: HEADER byte, then one code byte per channel (ONE_CODE or ZERO_CODE).
- Single-clock successor to the fixed 9-flag encoder: channel count, period and codes are parametrised; adds snapshotting, on-demand send, request queuing and overrun reporting.

Parameters:
- N_CH, 9, number of status channels (1..64).
- PERIOD_S, 20, packet period in tick_1hz pulses (>=1).
- HEADER, 8'h33, packet start byte.
- ONE_CODE, 8'hB1, byte sent for a channel at 1.
- ZERO_CODE, 8'h30, byte sent for a channel at 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick_1hz  in  1  one-clk-wide enable pulse, once per second.
- send_now  in  1  one-clk request for an immediate packet.
- status  in  N_CH  live status flags; bit 0 is sent first.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to send.
- busy  out  1  a packet is in progress.
- overrun  out  1  sticky: a request was dropped.

Behaviour:
- Reset: every output is 0, including tx_data = 8'h00. FSM goes to IDLE; period counter, pending flag, snapshot and channel index all clear. Reset mid-packet aborts the packet and nothing resumes afterwards.
- Period counter: width $clog2(PERIOD_S)+1; increments only on tick_1hz.
  - On a tick with counter == PERIOD_S-1: counter returns to 0 and a periodic request is raised.
  - With PERIOD_S = 1, every tick raises a request.
- Request: req = periodic request OR send_now. When both occur in the same cycle they count as one request.
- Pending flag, 1 deep:
  - req while the FSM is not in IDLE, with pending = 0: set pending.
  - req while not in IDLE, with pending = 1: request is dropped and overrun is set to 1. Only rst clears overrun.
  - req in IDLE, or pending = 1 in IDLE: start a packet next cycle. pending clears.
- States:
  - IDLE: tx_valid = 0, busy = 0. On a start condition, latch status into the snapshot, set index = 0, go to HDR.
  - HDR: tx_valid = 1, tx_data = HEADER. On tx_valid && tx_ready go to CH.
  - CH: tx_valid = 1, tx_data = snap[index] ? ONE_CODE : ZERO_CODE.
    - On accept with index < N_CH-1: index increments.
    - On accept with index == N_CH-1: go to IDLE.
- busy = 1 in every state except IDLE.
- Latency: a req in IDLE at cycle t gives tx_valid = 1 with HEADER at t+1.
- Handshake:
  - A byte is transferred on any cycle where tx_valid && tx_ready.
  - tx_data is stable while tx_valid = 1 and tx_ready = 0.
  - After an accept, the next byte appears the following cycle and tx_valid stays high (back-to-back, one byte per cycle when tx_ready stays high).
  - tx_valid never drops between bytes of a packet.
- Packet length is N_CH+1 bytes.
- After the last accept the FSM spends at least one cycle in IDLE, even when pending = 1. A pending packet therefore starts with HEADER two cycles after the last accept.
- Status changes after the snapshot do not affect the packet in flight.
- The period counter keeps running while a packet is sent.

Optional Feature:
- Macro: STATUS_PKT_CHECKSUM_EN.
- Defined: after the last channel byte, a CSUM state sends one extra byte. Its value is the XOR of HEADER and all channel bytes of the packet, computed from the snapshot. Packet length becomes N_CH+2; busy stays high through CSUM; return to IDLE on accept of CSUM.
- Undefined: no CSUM state, packet length N_CH+1, no checksum logic is synthesised.

Test Plan:
- Reset and periodic send:
  - Stimulus: N_CH = 9, PERIOD_S = 20, status = 9'b1_0000_0101, tx_ready held at 1, 20 ticks.
  - Response: after the 20th tick, 10 consecutive accepted bytes: 33, B1, 30, B1, 30, 30, 30, 30, 30, B1. busy is high for exactly 10 cycles.
- Backpressure:
  - Stimulus: tx_ready toggles 0,0,1 repeatedly during a packet.
  - Response: tx_data is constant during stall cycles, each byte is accepted exactly once, and the byte order matches the periodic-send case.
- Snapshot:
  - Stimulus: send_now with status = all 1s, then set status = 0 one cycle into HDR.
  - Response: every channel byte is B1.
- Queue and overrun:
  - Stimulus: tx_ready = 0; send_now is pulsed three times during HDR.
  - Response: pending is set by the first pulse and overrun rises on the second. After release, exactly two packets are sent, with 1 idle cycle between them.
- Simultaneous request and reset:
  - Stimulus: a terminal tick coincides with send_now.
  - Response: exactly one packet, and overrun stays 0.
  - Stimulus: assert rst at byte 4.
  - Response: tx_valid = 0 immediately, and no further bytes until the next request.
- Checksum (macro defined):
  - Stimulus: N_CH = 3, status = 3'b011.
  - Response: bytes 33, B1, B1, 30, then 33^B1^B1^30 = 8'h03.

Source files
------------

// File: rtl/status_packet_encoder.sv
// Periodic/on-demand status telemetry serializer: HEADER followed by one code byte per channel.
// Optional trailing XOR checksum byte when STATUS_PKT_CHECKSUM_EN is defined.
module status_packet_encoder #(
    parameter int          N_CH      = 9,
    parameter int          PERIOD_S  = 20,
    parameter logic [7:0]  HEADER    = 8'h33,
    parameter logic [7:0]  ONE_CODE  = 8'hB1,
    parameter logic [7:0]  ZERO_CODE = 8'h30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1hz,
    input  logic            send_now,
    input  logic [N_CH-1:0] status,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    output logic            busy,
    output logic            overrun
);

    localparam int CW = $clog2(PERIOD_S) + 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_S - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_CH   = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            ovr_q, ovr_d;
    logic [N_CH-1:0] snap_q, snap_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            per_req_s, req_s, accept_s;

    function automatic logic [7:0] chan_byte(input logic b);
        return b ? ONE_CODE : ZERO_CODE;
    endfunction

`ifdef STATUS_PKT_CHECKSUM_EN
    function automatic logic [7:0] calc_csum(input logic [N_CH-1:0] s);
        logic [7:0] acc;
        acc = HEADER;
        for (int i = 0; i < N_CH; i++) begin
            acc = acc ^ chan_byte(s[i]);
        end
        return acc;
    endfunction
`endif

    // Next-state, request arbitration and the next value of the registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        per_req_s = 1'b0;
        data_d    = 8'h00;

        if (tick_1hz) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d     = '0;
                per_req_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        req_s    = per_req_s | send_now;
        accept_s = valid_q & tx_ready;

        case (state_q)
            S_IDLE: begin
                if (req_s || pend_q) begin
                    state_d = S_HDR;
                    snap_d  = status;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (accept_s) begin
                    state_d = S_CH;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_CH: begin
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
`ifdef STATUS_PKT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = S_CH;
                end
            end
`ifdef STATUS_PKT_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request arriving mid-packet is held once; a second one is lost.
        if ((state_q != S_IDLE) && req_s) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end else begin
            ovr_d = ovr_q;
        end

        valid_d = (state_d != S_IDLE);
        case (state_d)
            S_HDR:   data_d = HEADER;
            S_CH:    data_d = chan_byte(snap_d[idx_d]);
`ifdef STATUS_PKT_CHECKSUM_EN
            S_CSUM:  data_d = calc_csum(snap_d);
`endif
            default: data_d = 8'h00;
        endcase
    end

    // State, counter, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;
    assign busy     = valid_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_status_packet_encoder.sv
// Self-checking bench for status_packet_encoder: byte-queue reference model plus directed literal checks.
module tb_status_packet_encoder;

    localparam int N_CH     = 9;
    localparam int PERIOD_S = 20;
`ifdef STATUS_PKT_CHECKSUM_EN
    localparam int PKT_LEN  = N_CH + 2;
`else
    localparam int PKT_LEN  = N_CH + 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick_1hz = 1'b0;
    logic            send_now = 1'b0;
    logic [N_CH-1:0] status = '0;
    logic            tx_ready = 1'b1;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            busy;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int busy_cnt = 0;

    logic [7:0] mq[$];
    bit         m_pend = 1'b0;
    bit         m_ovr = 1'b0;
    int         m_ticks = 0;

    logic [7:0] log_q[$];
    bit         stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;

    logic [7:0] exp_per [0:9];

    status_packet_encoder #(
        .N_CH(N_CH), .PERIOD_S(PERIOD_S),
        .HEADER(8'h33), .ONE_CODE(8'hB1), .ZERO_CODE(8'h30)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .send_now(send_now),
        .status(status), .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a packet is a queue of bytes, one popped per handshake.
    initial forever begin
        bit per, rq, in_pkt;
        logic [7:0] x, b;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_pend  = 1'b0;
            m_ovr   = 1'b0;
            m_ticks = 0;
        end else begin
            per = tick_1hz && ((m_ticks % PERIOD_S) == PERIOD_S - 1);
            if (tick_1hz) m_ticks++;
            rq = per || send_now;
            in_pkt = (mq.size() != 0);
            if (in_pkt && tx_ready) void'(mq.pop_front());
            if (!in_pkt) begin
                if (rq || m_pend) begin
                    x = 8'h33;
                    mq.push_back(8'h33);
                    for (int i = 0; i < N_CH; i++) begin
                        b = status[i] ? 8'hB1 : 8'h30;
                        mq.push_back(b);
                        x = x ^ b;
                    end
`ifdef STATUS_PKT_CHECKSUM_EN
                    mq.push_back(x);
`endif
                    m_pend = 1'b0;
                end
            end else if (rq) begin
                if (m_pend) m_ovr = 1'b1;
                else        m_pend = 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("valid", tx_valid, mq.size() != 0);
            chk("busy", busy, mq.size() != 0);
            chk("overrun", overrun, m_ovr);
            if (mq.size() != 0) chk("data", tx_data, mq[0]);
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // Accepted-byte log and stall stability check at the active edge.
    initial forever begin
        @(posedge clk);
        if (!rst && cmp_en) begin
            if (stall_q && tx_valid) chk("stall_hold", tx_data, stall_data);
            stall_q = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) log_q.push_back(tx_data);
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic check_periodic_bytes(input string nm);
        chk({nm, "_len"}, log_q.size(), PKT_LEN);
        for (int i = 0; i < 10 && i < log_q.size(); i++) chk(nm, log_q[i], exp_per[i]);
`ifdef STATUS_PKT_CHECKSUM_EN
        if (log_q.size() > 10) chk({nm, "_csum"}, log_q[10], 8'h82);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        exp_per = '{8'h33, 8'hB1, 8'h30, 8'hB1, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'hB1};

        // Reset state
        cyc(3);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Periodic send after 20 ticks
        status = 9'b1_0000_0101;
        tx_ready = 1'b1;
        busy_cnt = 0;
        log_q.delete();
        for (int t = 0; t < PERIOD_S; t++) begin
            tick_1hz = 1'b1;
            cyc(1);
            tick_1hz = 1'b0;
            if (t == PERIOD_S - 2) chk("no_early_pkt", busy_cnt, 0);
            cyc(2);
        end
        cyc(15);
        check_periodic_bytes("periodic");
        chk("busy_cycles", busy_cnt, PKT_LEN);

        // Backpressure 0,0,1
        log_q.delete();
        tx_ready = 1'b0;
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        for (int k = 0; k < 45; k++) begin
            tx_ready = (k % 3 == 2);
            cyc(1);
        end
        tx_ready = 1'b1;
        cyc(3);
        check_periodic_bytes("backpressure");

        // Snapshot isolation
        log_q.delete();
        status = '1;
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        status = '0;
        cyc(15);
        chk("snap_len", log_q.size(), PKT_LEN);
        for (int i = 0; i < log_q.size(); i++) begin
            if (i == 0) chk("snap_hdr", log_q[i], 8'h33);
            else if (i <= N_CH) chk("snap_ch", log_q[i], 8'hB1);
            else chk("snap_csum", log_q[i], 8'h82);
        end

        // Queue and overrun
        log_q.delete();
        status = 9'b1_0000_0101;
        tx_ready = 1'b0;
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        cyc(1);
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        chk("ovr_after_first", overrun, 1'b0);
        cyc(1);
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        chk("ovr_after_second", overrun, 1'b1);
        cyc(1);
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        tx_ready = 1'b1;
        cyc(30);
        chk("queue_len", log_q.size(), 2 * PKT_LEN);
        if (log_q.size() == 2 * PKT_LEN) begin
            chk("queue_hdr0", log_q[0], 8'h33);
            chk("queue_hdr1", log_q[PKT_LEN], 8'h33);
        end
        chk("ovr_sticky", overrun, 1'b1);

        // Terminal tick coinciding with send_now
        do_reset();
        log_q.delete();
        for (int t = 0; t < PERIOD_S - 1; t++) begin
            tick_1hz = 1'b1;
            cyc(1);
            tick_1hz = 1'b0;
            cyc(1);
        end
        tick_1hz = 1'b1;
        send_now = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        send_now = 1'b0;
        cyc(20);
        chk("coincide_len", log_q.size(), PKT_LEN);
        chk("coincide_ovr", overrun, 1'b0);

        // Reset at byte 4
        log_q.delete();
        send_now = 1'b1;
        cyc(1);
        send_now = 1'b0;
        for (int k = 0; k < 20 && log_q.size() < 3; k++) cyc(1);
        chk("rst_wait", log_q.size(), 3);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", tx_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        cyc(2);
        rst = 1'b0;
        cyc(12);
        chk("post_rst_bytes", log_q.size(), 3);
        chk("post_rst_valid", tx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
